// File: rtl/bsg_fpu_minmax_reduce.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_fpu_minmax_reduce
//  Purpose  : Streaming binary32 min/max reduction. Elements arrive on a
//             valid/ready input. Each element is folded into a running
//             minNum/maxNum accumulator. After the element flagged last has
//             been folded, one result beat is held on a valid/yumi output
//             until it is consumed.
//  Ports    : clk_i, reset_i          - clock, synchronous active-high reset
//             data_i, v_i, last_i     - element stream in
//             ready_o                 - element accepted when v_i & ready_o
//             min_o, max_o            - reduced minimum / maximum
//             count_o                 - elements accepted (saturating)
//             invalid_o               - sticky signalling-NaN seen
//             v_o, yumi_i             - result valid / result consumed
//             min_idx_o, max_idx_o    - argmin/argmax, only when the macro
//                                       BSG_FPU_MINMAX_REDUCE_ARGIDX_EN is
//                                       defined
//  Revision : 1.0  initial release
// ============================================================================
module bsg_fpu_minmax_reduce #(
    parameter int cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [31:0]            data_i,
    input  logic                   v_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic [31:0]            min_o,
    output logic [31:0]            max_o,
    output logic [cnt_width_p-1:0] count_o,
    output logic                   invalid_o,
    output logic                   v_o,
    input  logic                   yumi_i
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
    ,
    output logic [cnt_width_p-1:0] min_idx_o,
    output logic [cnt_width_p-1:0] max_idx_o
`endif
);

    localparam logic [31:0] C_QNAN     = 32'h7FC0_0000;
    localparam logic [0:0]  C_ST_ACCUM = 1'b0;
    localparam logic [0:0]  C_ST_DONE  = 1'b1;

    // ------------------------------------------------------------------
    // Classification and minNum/maxNum helpers
    // ------------------------------------------------------------------
    function automatic logic f_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic f_is_snan(input logic [31:0] x);
        return f_is_nan(x) && !x[22];
    endfunction

    function automatic logic f_is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    // Strict a < b on non-NaN operands that are not both zero. Differing
    // signs decide directly. Otherwise the magnitude order is inverted
    // for negatives. Denormals order correctly by raw bit pattern.
    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31];
        else if (!a[31])
            return a[30:0] < b[30:0];
        else
            return a[30:0] > b[30:0];
    endfunction

    function automatic logic [31:0] f_fmin(input logic [31:0] a, input logic [31:0] b);
        if (f_is_nan(a) && f_is_nan(b)) return C_QNAN;
        if (f_is_nan(a))                return b;
        if (f_is_nan(b))                return a;
        if (f_is_zero(a) && f_is_zero(b))
            return {a[31] | b[31], 31'd0};
        return f_lt(b, a) ? b : a;
    endfunction

    function automatic logic [31:0] f_fmax(input logic [31:0] a, input logic [31:0] b);
        if (f_is_nan(a) && f_is_nan(b)) return C_QNAN;
        if (f_is_nan(a))                return b;
        if (f_is_nan(b))                return a;
        if (f_is_zero(a) && f_is_zero(b))
            return {a[31] & b[31], 31'd0};
        return f_lt(a, b) ? b : a;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic       w_accept;
    logic       w_reinit;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_state <= C_ST_ACCUM;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_ACCUM: if (w_accept && last_i) w_state_next = C_ST_DONE;
            C_ST_DONE:  if (yumi_i)             w_state_next = C_ST_ACCUM;
            default:                            w_state_next = C_ST_ACCUM;
        endcase
    end

    // Handshake outputs decode the state register alone, so ready_o
    // never depends on v_i and v_o has no path from the data input.
    always_comb begin
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (r_state)
            C_ST_ACCUM: ready_o = 1'b1;
            C_ST_DONE:  v_o     = 1'b1;
            default:    ready_o = 1'b0;
        endcase
    end

    assign w_accept = v_i & ready_o;
    // Consuming the result restarts the accumulator. ready_o is low in
    // DONE, so no element can be taken in that same cycle.
    assign w_reinit = (r_state == C_ST_DONE) & yumi_i;

    // ------------------------------------------------------------------
    // Accumulator datapath
    // ------------------------------------------------------------------
    logic [31:0]            r_acc_min;
    logic [31:0]            r_acc_max;
    logic [cnt_width_p-1:0] r_count;
    logic                   r_invalid;
    logic [31:0]            w_min_fold;
    logic [31:0]            w_max_fold;
    logic [cnt_width_p-1:0] w_count_inc;

    assign w_min_fold  = f_fmin(r_acc_min, data_i);
    assign w_max_fold  = f_fmax(r_acc_max, data_i);
    assign w_count_inc = (&r_count) ? r_count
                                    : r_count + {{(cnt_width_p-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (reset_i || w_reinit) begin
            r_acc_min <= C_QNAN;
            r_acc_max <= C_QNAN;
            r_count   <= '0;
            r_invalid <= 1'b0;
        end else if (w_accept) begin
            r_acc_min <= w_min_fold;
            r_acc_max <= w_max_fold;
            r_count   <= w_count_inc;
            r_invalid <= r_invalid | f_is_snan(data_i);
        end
    end

    assign min_o     = r_acc_min;
    assign max_o     = r_acc_max;
    assign count_o   = r_count;
    assign invalid_o = r_invalid;

`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
    // The index follows any bitwise change of the accumulator. Because
    // ties keep the accumulator, the index names the earliest element
    // equal to the result. A -0 replacing +0 is a bitwise change, so it
    // moves the index. All-ones marks a result that is still the init qNaN.
    logic [cnt_width_p-1:0] r_min_idx;
    logic [cnt_width_p-1:0] r_max_idx;

    always_ff @(posedge clk_i) begin
        if (reset_i || w_reinit) begin
            r_min_idx <= '1;
            r_max_idx <= '1;
        end else if (w_accept) begin
            if (w_min_fold != r_acc_min) r_min_idx <= r_count;
            if (w_max_fold != r_acc_max) r_max_idx <= r_count;
        end
    end

    assign min_idx_o = r_min_idx;
    assign max_idx_o = r_max_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_fpu_minmax_reduce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_fpu_minmax_reduce
//  Purpose  : Self-checking bench for bsg_fpu_minmax_reduce. It runs
//             directed packets and randomized packets against a
//             value-ordering reference model.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_bsg_fpu_minmax_reduce;

    localparam int          CW     = 16;
    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [31:0]   data_i;
    logic          v_i;
    logic          last_i;
    logic          ready_o;
    logic [31:0]   min_o;
    logic [31:0]   max_o;
    logic [CW-1:0] count_o;
    logic          invalid_o;
    logic          v_o;
    logic          yumi_i;
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
    logic [CW-1:0] min_idx_o;
    logic [CW-1:0] max_idx_o;
`endif

    always #5 clk = ~clk;

    bsg_fpu_minmax_reduce #(.cnt_width_p(CW)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .data_i    (data_i),
        .v_i       (v_i),
        .last_i    (last_i),
        .ready_o   (ready_o),
        .min_o     (min_o),
        .max_o     (max_o),
        .count_o   (count_o),
        .invalid_o (invalid_o),
        .v_o       (v_o),
        .yumi_i    (yumi_i)
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
        ,
        .min_idx_o (min_idx_o),
        .max_idx_o (max_idx_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: floats are ranked on a signed integer number line.
    // The NaN and zero rules are applied before ranking.
    // ------------------------------------------------------------------
    function automatic bit m_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic longint m_key(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] m_pick(input logic [31:0] a, input logic [31:0] b, input bit want_min);
        if (m_nan(a) && m_nan(b)) return C_QNAN;
        if (m_nan(a)) return b;
        if (m_nan(b)) return a;
        if (m_key(a) == 0 && m_key(b) == 0)
            return want_min ? {a[31] | b[31], 31'd0} : {a[31] & b[31], 31'd0};
        if (want_min) return (m_key(b) < m_key(a)) ? b : a;
        return (m_key(a) < m_key(b)) ? b : a;
    endfunction

    logic [31:0] pkt[$];
    logic [31:0] exp_min, exp_max, exp_min_idx, exp_max_idx;
    logic        exp_inv;

    function automatic logic [31:0] first_index(input logic [31:0] r);
        if (r == C_QNAN) return 32'h0000_FFFF;
        foreach (pkt[j]) if (pkt[j] == r) return 32'(j);
        return 32'h0000_FFFF;
    endfunction

    task automatic compute_expected();
        exp_min = C_QNAN;
        exp_max = C_QNAN;
        exp_inv = 1'b0;
        foreach (pkt[j]) begin
            exp_min = m_pick(exp_min, pkt[j], 1'b1);
            exp_max = m_pick(exp_max, pkt[j], 1'b0);
            if (m_nan(pkt[j]) && !pkt[j][22]) exp_inv = 1'b1;
        end
        exp_min_idx = first_index(exp_min);
        exp_max_idx = first_index(exp_max);
    endtask

    task automatic check_init(input string tag);
        check_eq({tag, ":v_o"},     32'(v_o),       32'd0);
        check_eq({tag, ":ready"},   32'(ready_o),   32'd1);
        check_eq({tag, ":min"},     min_o,          C_QNAN);
        check_eq({tag, ":max"},     max_o,          C_QNAN);
        check_eq({tag, ":count"},   32'(count_o),   32'd0);
        check_eq({tag, ":invalid"}, 32'(invalid_o), 32'd0);
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
        check_eq({tag, ":min_idx"}, 32'(min_idx_o), 32'h0000_FFFF);
        check_eq({tag, ":max_idx"}, 32'(max_idx_o), 32'h0000_FFFF);
`endif
    endtask

    task automatic check_result(input string tag);
        check_eq({tag, ":v_o"},     32'(v_o),       32'd1);
        check_eq({tag, ":ready"},   32'(ready_o),   32'd0);
        check_eq({tag, ":min"},     min_o,          exp_min);
        check_eq({tag, ":max"},     max_o,          exp_max);
        check_eq({tag, ":count"},   32'(count_o),   32'(pkt.size()));
        check_eq({tag, ":invalid"}, 32'(invalid_o), 32'(exp_inv));
`ifdef BSG_FPU_MINMAX_REDUCE_ARGIDX_EN
        check_eq({tag, ":min_idx"}, 32'(min_idx_o), exp_min_idx);
        check_eq({tag, ":max_idx"}, 32'(max_idx_o), exp_max_idx);
`endif
    endtask

    // Streams pkt one element per cycle, checks the result one cycle after
    // the last beat, holds it for 'hold' cycles while offering unwanted
    // beats, then consumes it. A beat is also offered during the yumi cycle.
    task automatic run_packet(input string tag, input int hold);
        compute_expected();
        foreach (pkt[i]) begin
            @(negedge clk);
            check_eq({tag, ":acc_ready"}, 32'(ready_o), 32'd1);
            check_eq({tag, ":acc_v_o"},   32'(v_o),     32'd0);
            v_i    = 1'b1;
            data_i = pkt[i];
            last_i = (i == pkt.size() - 1);
        end
        @(negedge clk);
        v_i    = 1'b0;
        last_i = 1'b0;
        check_result(tag);
        for (int k = 0; k < hold; k++) begin
            v_i    = 1'b1;
            data_i = $urandom;
            last_i = 1'b1;
            @(negedge clk);
            check_result({tag, ":hold"});
        end
        v_i    = 1'b1;
        data_i = 32'hC2C8_0000;
        last_i = 1'b1;
        yumi_i = 1'b1;
        @(negedge clk);
        v_i    = 1'b0;
        last_i = 1'b0;
        yumi_i = 1'b0;
        check_init({tag, ":post"});
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return C_QNAN;
            3:       return {r[31], 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3F_FFFF))};
            4:       return {r[31], 8'hFF, 23'd0};
            5:       return {r[31], 8'h00, r[22:0]};
            6:       return r[0] ? 32'h3F80_0000 : 32'hBF80_0000;
            7:       return {r[31], 8'h7F, 20'd0, r[2:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        yumi_i  = 1'b0;
        repeat (2) @(negedge clk);
        check_init("reset");
        reset_i = 1'b0;

        pkt = '{32'h3F80_0000, 32'hC000_0000, 32'h4060_0000};
        run_packet("basic", 0);

        pkt = '{32'h0000_0000, 32'h8000_0000};
        run_packet("zeros", 0);

        pkt = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000};
        run_packet("nan", 0);

        pkt = '{32'h7FC0_0000, 32'hFF80_0001, 32'h7FFF_FFFF};
        run_packet("allnan", 0);

        pkt = '{32'h4120_0000, 32'hBF00_0000};
        run_packet("backpr", 5);

        pkt = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        run_packet("ties", 0);

        pkt = '{32'h0000_0001, 32'h8000_0003, 32'h0000_0002};
        run_packet("denorm", 1);

        // Mid-packet reset: two beats, then reset in the following cycle.
        @(negedge clk);
        v_i = 1'b1; data_i = 32'h4000_0000; last_i = 1'b0;
        @(negedge clk);
        data_i = 32'hC100_0000;
        @(negedge clk);
        v_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check_init("midrst");
        pkt = '{32'h4060_0000};
        run_packet("midrst_pkt", 0);

        for (int n = 0; n < 300; n++) begin
            int len;
            len = $urandom_range(1, 7);
            pkt.delete();
            for (int j = 0; j < len; j++) pkt.push_back(rand_val());
            run_packet("rand", $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
